// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO user and the fifo_ctrl pointer controller.
// Overflow/underflow members exist only when FIFO_CTRL_ERR_EN is defined.
interface fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  i_wr;
    logic                  i_rd;
    logic                  o_w_en;
    logic [ADDR_WIDTH-1:0] o_w_addr;
    logic [ADDR_WIDTH-1:0] o_r_addr;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_almost_full;
    logic                  o_almost_empty;
    logic [ADDR_WIDTH:0]   o_level;
`ifdef FIFO_CTRL_ERR_EN
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output i_wr, i_rd,
        input  o_w_en, o_w_addr, o_r_addr, o_full, o_empty,
               o_almost_full, o_almost_empty, o_level, o_overflow, o_underflow
    );

    modport slave (
        input  i_wr, i_rd,
        output o_w_en, o_w_addr, o_r_addr, o_full, o_empty,
               o_almost_full, o_almost_empty, o_level, o_overflow, o_underflow
    );
`else
    modport master (
        output i_wr, i_rd,
        input  o_w_en, o_w_addr, o_r_addr, o_full, o_empty,
               o_almost_full, o_almost_empty, o_level
    );

    modport slave (
        input  i_wr, i_rd,
        output o_w_en, o_w_addr, o_r_addr, o_full, o_empty,
               o_almost_full, o_almost_empty, o_level
    );
`endif
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/status controller driving a 2**ADDR_WIDTH-entry register file as a first-word-fall-through FIFO.
// Define FIFO_CTRL_ERR_EN to add sticky overflow/underflow flags.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    fifo_ctrl_if.slave  bus
);
    localparam int                  DEPTH   = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] r_wAddr;
    logic [ADDR_WIDTH-1:0] r_rAddr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almostFull;
    logic                  r_almostEmpty;
    logic [ADDR_WIDTH:0]   w_levelNext;
    logic                  w_pushOk;
    logic                  w_popOk;

    // A push into a full FIFO still succeeds when a pop frees the slot in the same cycle.
    assign w_pushOk = bus.i_wr & (~r_full | bus.i_rd);
    assign w_popOk  = bus.i_rd & ~r_empty;

    always_comb begin
        w_levelNext = r_level;
        case ({w_pushOk, w_popOk})
            2'b10:   w_levelNext = r_level + 1'b1;
            2'b01:   w_levelNext = r_level - 1'b1;
            default: w_levelNext = r_level;
        endcase
    end

    // Flags are derived from the next level so they are valid right after the edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wAddr       <= '0;
            r_rAddr       <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almostFull  <= 1'b0;
            r_almostEmpty <= 1'b1;
        end else begin
            if (w_pushOk) r_wAddr <= r_wAddr + 1'b1;
            if (w_popOk)  r_rAddr <= r_rAddr + 1'b1;
            r_level       <= w_levelNext;
            r_full        <= (w_levelNext == DEPTH_L);
            r_empty       <= (w_levelNext == '0);
            r_almostFull  <= (w_levelNext >= AF_L);
            r_almostEmpty <= (w_levelNext <= AE_L);
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow  | (bus.i_wr & r_full & ~bus.i_rd);
            r_underflow <= r_underflow | (bus.i_rd & r_empty);
        end
    end

    assign bus.o_overflow  = r_overflow;
    assign bus.o_underflow = r_underflow;
`endif

    assign bus.o_w_en         = w_pushOk;
    assign bus.o_w_addr       = r_wAddr;
    assign bus.o_r_addr       = r_rAddr;
    assign bus.o_level        = r_level;
    assign bus.o_full         = r_full;
    assign bus.o_empty        = r_empty;
    assign bus.o_almost_full  = r_almostFull;
    assign bus.o_almost_empty = r_almostEmpty;
endmodule
